// File: rtl/read_after_write_gate_pkg.sv
// Shared types and helpers for the read-after-write ordering gate.
// Address field widths normally come from the memory-map defines; the
// fallback values below keep this slice self-contained.
`ifndef ROW_ADDR_BITS
`define ROW_ADDR_BITS 14
`endif
`ifndef COL_ADDR_BITS
`define COL_ADDR_BITS 10
`endif
`ifndef BANK_ADDR_BITS
`define BANK_ADDR_BITS 3
`endif

package read_after_write_gate_pkg;

  localparam int SNAP_DEPTH = 8;
  localparam int ADDR_W     = `ROW_ADDR_BITS + `COL_ADDR_BITS + `BANK_ADDR_BITS;

  typedef enum logic [2:0] {
    IDLE,
    CHECK,
    WAIT_POP,
    WAIT_WIN,
    ISSUE
  } raw_gate_state_t;

  // Pops still required before the youngest matching write has drained.
  // Valid entries occupy the top nvalid slots, so the match sits at
  // position k-(8-nvalid) counted from the oldest valid entry. A pop in
  // the same cycle already retires one of them.
  function automatic logic [3:0] pops_needed(input logic [2:0] k,
                                             input logic [3:0] nvalid,
                                             input logic       pop_now);
    logic [4:0] span;
    logic [3:0] need;
    span = 5'(k) + 5'(nvalid) + 5'd1;
    if (span > 5'd8) begin
      need = span[3:0] - 4'd8;
    end else begin
      need = 4'd0;
    end
    if (pop_now && (need != 4'd0)) begin
      need = need - 4'd1;
    end
    return need;
  endfunction

endpackage

// File: rtl/read_after_write_gate_match.sv
// Combinational compare of a held read address against the write-address
// snapshot. Reports how many snapshot entries are valid and the index of
// the youngest valid entry whose address matches exactly.
module raw_match_unit
  import read_after_write_gate_pkg::*;
#(
  parameter int DATA_WIDTH = ADDR_W
) (
  input  logic [SNAP_DEPTH-1:0][DATA_WIDTH:0] snap,
  input  logic [DATA_WIDTH-1:0]               hold_addr,
  output logic [3:0]                          nvalid,
  output logic                                match,
  output logic [2:0]                          k
);

  // Scan oldest to newest so the last hit left in k is the youngest match.
  always_comb begin
    nvalid = 4'd0;
    match  = 1'b0;
    k      = 3'd0;
    for (int i = 0; i < SNAP_DEPTH; i++) begin
      if (snap[i][DATA_WIDTH]) begin
        nvalid = nvalid + 4'd1;
        if (snap[i][DATA_WIDTH-1:0] == hold_addr) begin
          match = 1'b1;
          k     = 3'(i);
        end
      end
    end
  end

endmodule

// File: rtl/read_after_write_gate.sv
// Holds one read request until every older write to the same address has
// drained from the write FIFO, then hands it to the command scheduler.
module read_after_write_gate
  import read_after_write_gate_pkg::*;
#(
  parameter int DATA_WIDTH = ADDR_W,
  parameter int STALL_MAX  = 1024,
  parameter int CNT_W      = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic                  i_rd_valid,
  input  logic [DATA_WIDTH-1:0] i_rd_addr,
  output logic                  o_rd_ready,
  input  logic [DATA_WIDTH:0]   i_waddr_0,
  input  logic [DATA_WIDTH:0]   i_waddr_1,
  input  logic [DATA_WIDTH:0]   i_waddr_2,
  input  logic [DATA_WIDTH:0]   i_waddr_3,
  input  logic [DATA_WIDTH:0]   i_waddr_4,
  input  logic [DATA_WIDTH:0]   i_waddr_5,
  input  logic [DATA_WIDTH:0]   i_waddr_6,
  input  logic [DATA_WIDTH:0]   i_waddr_7,
  input  logic                  i_wfifo_pop,
  output logic                  o_cmd_valid,
  output logic [DATA_WIDTH-1:0] o_cmd_addr,
  input  logic                  i_cmd_ready,
  output logic                  o_stall,
  output logic [CNT_W-1:0]      o_hazard_cnt,
  output logic                  o_timeout
);

  localparam int STALL_W = $clog2(STALL_MAX + 1);

  raw_gate_state_t                    state;
  logic [DATA_WIDTH-1:0]              hold_addr;
  logic [3:0]                         pop_cnt;
  logic                               read_stalled;
  logic [STALL_W-1:0]                 stall_cnt;
  logic [SNAP_DEPTH-1:0][DATA_WIDTH:0] snap;
  logic [3:0]                         nvalid;
  logic                               match;
  logic [2:0]                         k;
  logic [3:0]                         need;
  logic                               hazard_sat;

  assign snap = {i_waddr_7, i_waddr_6, i_waddr_5, i_waddr_4,
                 i_waddr_3, i_waddr_2, i_waddr_1, i_waddr_0};

  raw_match_unit #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_match (
    .snap      (snap),
    .hold_addr (hold_addr),
    .nvalid    (nvalid),
    .match     (match),
    .k         (k)
  );

  assign need       = pops_needed(k, nvalid, i_wfifo_pop);
  assign hazard_sat = &o_hazard_cnt;

  // Gate FSM with registered handshake outputs; a read is counted as a
  // hazard only the first time it stalls, however often it re-checks.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      hold_addr    <= '0;
      pop_cnt      <= 4'd0;
      read_stalled <= 1'b0;
      o_rd_ready   <= 1'b1;
      o_cmd_valid  <= 1'b0;
      o_cmd_addr   <= '0;
      o_stall      <= 1'b0;
      o_hazard_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_rd_valid && o_rd_ready) begin
            hold_addr    <= i_rd_addr;
            read_stalled <= 1'b0;
            o_rd_ready   <= 1'b0;
            state        <= CHECK;
          end
        end
        CHECK: begin
          if (match && (need != 4'd0)) begin
            pop_cnt <= need;
            o_stall <= 1'b1;
            state   <= WAIT_POP;
            if (!read_stalled) begin
              read_stalled <= 1'b1;
              if (!hazard_sat) o_hazard_cnt <= o_hazard_cnt + 1'b1;
            end
          end else if (!match && (nvalid == 4'd8)) begin
            o_stall <= 1'b1;
            state   <= WAIT_WIN;
            if (!read_stalled) begin
              read_stalled <= 1'b1;
              if (!hazard_sat) o_hazard_cnt <= o_hazard_cnt + 1'b1;
            end
          end else begin
            o_cmd_valid <= 1'b1;
            o_cmd_addr  <= hold_addr;
            state       <= ISSUE;
          end
        end
        WAIT_POP: begin
          if (i_wfifo_pop) begin
            pop_cnt <= pop_cnt - 4'd1;
            if (pop_cnt == 4'd1) begin
              o_stall     <= 1'b0;
              o_cmd_valid <= 1'b1;
              o_cmd_addr  <= hold_addr;
              state       <= ISSUE;
            end
          end
        end
        WAIT_WIN: begin
          if (nvalid < 4'd8) begin
            o_stall <= 1'b0;
            state   <= CHECK;
          end
        end
        ISSUE: begin
          if (i_cmd_ready) begin
            o_cmd_valid <= 1'b0;
            o_rd_ready  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          o_stall     <= 1'b0;
          o_cmd_valid <= 1'b0;
          o_rd_ready  <= 1'b1;
          state       <= IDLE;
        end
      endcase
    end
  end

  // Length of the current stall; a long stall raises a sticky timeout flag
  // but the read is still kept and released normally later.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      stall_cnt <= '0;
      o_timeout <= 1'b0;
    end else if (o_stall) begin
      if (stall_cnt != STALL_W'(STALL_MAX)) stall_cnt <= stall_cnt + STALL_W'(1);
      if (stall_cnt >= STALL_W'(STALL_MAX - 1)) o_timeout <= 1'b1;
    end else begin
      stall_cnt <= '0;
    end
  end

endmodule

// File: tb/tb_read_after_write_gate.sv
// Bench for read_after_write_gate: a per-cycle vector table for the
// directed scenarios, async-reset sequences, then random traffic checked
// against a write-queue model that tracks the youngest older matching write
// by tag.
`timescale 1ns/1ps
module tb_read_after_write_gate;
  import read_after_write_gate_pkg::*;

  localparam int AW        = ADDR_W;
  localparam int STALL_LIM = 4;
  localparam int HCW       = 2;
  localparam int HMAX      = 3;

  typedef logic [AW-1:0] addr_t;

  typedef struct {
    int rst;
    int snap;
    int rv;
    int pop;
    int cr;
    int ev;
    int er;
    int es;
    int eh;
    int et;
  } vec_t;

  typedef struct {
    addr_t a;
    int    tag;
  } wr_t;

  typedef enum {M_IDLE, M_CHK, M_WTAG, M_WWIN, M_ISSUE} mphase_t;

  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           rd_valid = 1'b0;
  addr_t          rd_addr = '0;
  logic           rd_ready;
  logic [AW:0]    waddr [8];
  logic           wfifo_pop = 1'b0;
  logic           cmd_valid;
  addr_t          cmd_addr;
  logic           cmd_ready = 1'b0;
  logic           stall;
  logic [HCW-1:0] hazard_cnt;
  logic           timeout;

  int checks = 0;
  int failures = 0;

  addr_t A = 'h123;
  addr_t B = 'h200;
  addr_t C = 'h3f5;
  addr_t pool [4];
  vec_t  vecs [$];

  always #5 clk = ~clk;

  read_after_write_gate #(
    .DATA_WIDTH(AW),
    .STALL_MAX (STALL_LIM),
    .CNT_W     (HCW)
  ) dut (
    .i_clk        (clk),
    .i_rst_n      (rst_n),
    .i_rd_valid   (rd_valid),
    .i_rd_addr    (rd_addr),
    .o_rd_ready   (rd_ready),
    .i_waddr_0    (waddr[0]),
    .i_waddr_1    (waddr[1]),
    .i_waddr_2    (waddr[2]),
    .i_waddr_3    (waddr[3]),
    .i_waddr_4    (waddr[4]),
    .i_waddr_5    (waddr[5]),
    .i_waddr_6    (waddr[6]),
    .i_waddr_7    (waddr[7]),
    .i_wfifo_pop  (wfifo_pop),
    .o_cmd_valid  (cmd_valid),
    .o_cmd_addr   (cmd_addr),
    .i_cmd_ready  (cmd_ready),
    .o_stall      (stall),
    .o_hazard_cnt (hazard_cnt),
    .o_timeout    (timeout)
  );

  function automatic vec_t mk(int rst, int snap, int rv, int pop, int cr,
                              int ev, int er, int es, int eh, int et);
    vec_t v;
    v.rst = rst; v.snap = snap; v.rv = rv; v.pop = pop; v.cr = cr;
    v.ev = ev; v.er = er; v.es = es; v.eh = eh; v.et = et;
    return v;
  endfunction

  task automatic checkOutput(input string nm, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("[TB] FAIL %s: got %0h, expected %0h", nm, act, expv);
    end
  endtask

  task automatic checkAll(input string tag, input logic ev, input addr_t ea, input logic er,
                          input logic es, input int eh, input logic et);
    checkOutput({tag, ".cmd_valid"}, 64'(cmd_valid), 64'(ev));
    if (ev) checkOutput({tag, ".cmd_addr"}, 64'(cmd_addr), 64'(ea));
    checkOutput({tag, ".rd_ready"}, 64'(rd_ready), 64'(er));
    checkOutput({tag, ".stall"}, 64'(stall), 64'(es));
    checkOutput({tag, ".hazard_cnt"}, 64'(hazard_cnt), 64'(eh));
    checkOutput({tag, ".timeout"}, 64'(timeout), 64'(et));
  endtask

  // Preset snapshots used by the vector table.
  task automatic setSnap(input int sel);
    for (int i = 0; i < 8; i++) waddr[i] = '0;
    case (sel)
      1: begin
        waddr[5] = {1'b1, B}; waddr[6] = {1'b1, A}; waddr[7] = {1'b1, C};
      end
      2: begin
        waddr[4] = {1'b1, B}; waddr[5] = {1'b1, A};
        waddr[6] = {1'b1, C}; waddr[7] = {1'b1, A};
      end
      3: for (int i = 0; i < 8; i++) waddr[i] = {1'b1, B + addr_t'(i)};
      4: for (int i = 1; i < 8; i++) waddr[i] = {1'b1, B + addr_t'(i)};
      5: begin
        waddr[2] = {1'b0, A};
        waddr[5] = {1'b1, B}; waddr[6] = {1'b1, A ^ addr_t'(1)}; waddr[7] = {1'b1, C};
      end
      default: ;
    endcase
  endtask

  task automatic applyStimulus(input vec_t v);
    @(negedge clk);
    setSnap(v.snap);
    rd_valid  = (v.rv != 0);
    rd_addr   = A;
    wfifo_pop = (v.pop != 0);
    cmd_ready = (v.cr != 0);
    if (v.rst != 0) begin
      rst_n = 1'b0;
      #1;
      rst_n = 1'b1;
    end
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    rd_valid = 1'b0; wfifo_pop = 1'b0; cmd_ready = 1'b0;
    setSnap(0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Random-traffic model state.
  wr_t     wq [$];
  mphase_t phase, nphase;
  addr_t   maddr;
  int      wait_tag, tagc, run, mh, p;
  logic    mto, mstalled;
  logic    rv, pop, push, cr;
  addr_t   ra;

  initial begin
    pool[0] = A; pool[1] = B; pool[2] = A ^ addr_t'(1); pool[3] = C;

    // rst snap rv pop cr | cmd_valid rd_ready stall hazard timeout
    vecs.push_back(mk(0,0,1,0,1, 0,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1, 1,0,0,0,0));
    vecs.push_back(mk(0,0,0,0,1, 0,1,0,0,0));
    vecs.push_back(mk(0,1,1,0,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,1, 0,0,1,1,0));
    vecs.push_back(mk(0,1,0,1,1, 0,0,1,1,0));
    vecs.push_back(mk(0,1,0,1,1, 1,0,0,1,0));
    vecs.push_back(mk(0,1,0,0,1, 0,1,0,1,0));
    vecs.push_back(mk(0,1,1,0,1, 0,0,0,1,0));
    vecs.push_back(mk(0,1,0,1,1, 0,0,1,2,0));
    vecs.push_back(mk(0,1,0,0,1, 0,0,1,2,0));
    vecs.push_back(mk(0,1,0,1,1, 1,0,0,2,0));
    vecs.push_back(mk(0,1,0,0,1, 0,1,0,2,0));
    vecs.push_back(mk(0,1,1,0,1, 0,0,0,2,0));
    vecs.push_back(mk(0,1,0,0,1, 0,0,1,3,0));
    vecs.push_back(mk(0,2,0,1,1, 0,0,1,3,0));
    vecs.push_back(mk(0,2,0,1,1, 1,0,0,3,0));
    vecs.push_back(mk(0,2,0,0,1, 0,1,0,3,0));
    vecs.push_back(mk(0,1,1,0,1, 0,0,0,3,0));
    vecs.push_back(mk(0,1,0,0,1, 0,0,1,3,0));
    vecs.push_back(mk(0,1,0,1,1, 0,0,1,3,0));
    vecs.push_back(mk(0,1,0,1,1, 1,0,0,3,0));
    vecs.push_back(mk(0,1,0,0,1, 0,1,0,3,0));
    vecs.push_back(mk(0,5,1,0,1, 0,0,0,3,0));
    vecs.push_back(mk(0,5,0,0,1, 1,0,0,3,0));
    vecs.push_back(mk(0,5,0,0,1, 0,1,0,3,0));
    vecs.push_back(mk(1,0,0,0,1, 0,1,0,0,0));
    vecs.push_back(mk(0,3,1,0,1, 0,0,0,0,0));
    vecs.push_back(mk(0,3,0,0,1, 0,0,1,1,0));
    vecs.push_back(mk(0,3,0,1,1, 0,0,1,1,0));
    vecs.push_back(mk(0,4,0,0,1, 0,0,0,1,0));
    vecs.push_back(mk(0,4,0,0,1, 1,0,0,1,0));
    vecs.push_back(mk(0,4,0,0,1, 0,1,0,1,0));
    vecs.push_back(mk(1,0,0,0,1, 0,1,0,0,0));
    vecs.push_back(mk(0,1,1,0,1, 0,0,0,0,0));
    vecs.push_back(mk(0,1,0,0,1, 0,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,1, 0,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,1, 0,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,1, 0,0,1,1,0));
    vecs.push_back(mk(0,1,0,0,1, 0,0,1,1,1));
    vecs.push_back(mk(0,1,0,1,1, 0,0,1,1,1));
    vecs.push_back(mk(0,1,0,1,0, 1,0,0,1,1));
    vecs.push_back(mk(0,1,0,0,0, 1,0,0,1,1));
    vecs.push_back(mk(0,1,0,0,0, 1,0,0,1,1));
    vecs.push_back(mk(0,1,0,0,0, 1,0,0,1,1));
    vecs.push_back(mk(0,1,0,0,1, 0,1,0,1,1));

    applyReset();
    #1;
    checkAll("reset", 1'b0, A, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("reset.cmd_addr", 64'(cmd_addr), 64'(0));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      @(posedge clk);
      #1;
      checkAll($sformatf("vec%0d", i), vecs[i].ev != 0, A, vecs[i].er != 0,
               vecs[i].es != 0, vecs[i].eh, vecs[i].et != 0);
    end

    // Async reset while a command is waiting for the scheduler.
    @(negedge clk);
    setSnap(0); rd_valid = 1'b1; rd_addr = A; cmd_ready = 1'b0; wfifo_pop = 1'b0;
    @(posedge clk); #1;
    @(negedge clk); rd_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_issue.pre_valid", 64'(cmd_valid), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    checkAll("rst_issue", 1'b0, A, 1'b1, 1'b0, 0, 1'b0);
    checkOutput("rst_issue.cmd_addr", 64'(cmd_addr), 64'(0));
    @(negedge clk); rst_n = 1'b1;

    // Async reset in the middle of a hazard stall discards the read.
    @(negedge clk);
    setSnap(1); rd_valid = 1'b1; cmd_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk); rd_valid = 1'b0;
    @(posedge clk); #1;
    checkOutput("rst_stall.pre_stall", 64'(stall), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    checkAll("rst_stall", 1'b0, A, 1'b1, 1'b0, 0, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); wfifo_pop = 1'b1;
      @(posedge clk); #1;
      checkOutput($sformatf("rst_stall.after%0d.cmd_valid", i), 64'(cmd_valid), 64'(0));
    end

    // Random traffic against the write-queue model.
    applyReset();
    wq.delete();
    phase = M_IDLE; tagc = 0; run = 0; mh = 0; mto = 1'b0; mstalled = 1'b0;
    maddr = '0; wait_tag = -1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      rv   = ($urandom_range(0, 1) == 1);
      ra   = pool[$urandom_range(0, 3)];
      pop  = (wq.size() > 0) && ($urandom_range(0, 2) != 0);
      push = ($urandom_range(0, 1) == 1) && ((wq.size() - (pop ? 1 : 0)) < 8);
      cr   = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < 8; i++) waddr[i] = '0;
      for (int i = 0; i < wq.size(); i++) waddr[8 - wq.size() + i] = {1'b1, wq[i].a};
      rd_valid = rv; rd_addr = ra; wfifo_pop = pop; cmd_ready = cr;

      if (phase == M_WTAG || phase == M_WWIN) begin
        run++;
        if (run >= STALL_LIM) mto = 1'b1;
      end else begin
        run = 0;
      end

      nphase = phase;
      case (phase)
        M_IDLE: if (rv) begin maddr = ra; mstalled = 1'b0; nphase = M_CHK; end
        M_CHK: begin
          p = -1;
          for (int i = 0; i < wq.size(); i++) if (wq[i].a == maddr) p = i;
          if (p >= 0 && !(p == 0 && pop)) begin
            wait_tag = wq[p].tag;
            nphase = M_WTAG;
          end else if (p < 0 && wq.size() == 8) begin
            nphase = M_WWIN;
          end else begin
            nphase = M_ISSUE;
          end
          if ((nphase == M_WTAG || nphase == M_WWIN) && !mstalled) begin
            mstalled = 1'b1;
            if (mh < HMAX) mh++;
          end
        end
        M_WTAG:  if (pop && wq[0].tag == wait_tag) nphase = M_ISSUE;
        M_WWIN:  if (wq.size() < 8) nphase = M_CHK;
        M_ISSUE: if (cr) nphase = M_IDLE;
        default: nphase = M_IDLE;
      endcase

      if (pop) void'(wq.pop_front());
      if (push) begin
        wq.push_back('{pool[$urandom_range(0, 3)], tagc});
        tagc++;
      end
      phase = nphase;

      @(posedge clk);
      #1;
      checkAll($sformatf("rand%0d", cyc), phase == M_ISSUE, maddr, phase == M_IDLE,
               phase == M_WTAG || phase == M_WWIN, mh, mto);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
